seg7_scan_reader: RTL
=====================

Name: seg7_scan_reader

Overview:
- Reads a multiplexed, scanned seven-segment display bus: a shared segment pattern plus a one-hot digit select.
- Converts each stable segment pattern back to its 4-bit hex value and stores it in that digit's register.
- Acts as the receiving end of the 4-bit to 7-segment decode path. It self-checks the frequency-meter display output and lets the meter readout be recovered in the bench or on chip.
- Flags patterns that are neither a legal glyph nor blank.

Parameters:
- DIGITS, 8, number of scanned digit positions (1..16).
- STABLE_CYCLES, 4, consecutive identical samples required before a commit (>=1).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- segment  input  7  segment pattern, bit0=a .. bit6=g; 1 = lit.
- digit_sel  input  DIGITS  one-hot, active-high digit enable.
- clear  input  1  synchronous clear of stored values (not of the FSM error history).
- value  output  4*DIGITS  recovered nibbles; digit i is at [4i+3:4i].
- valid_mask  output  DIGITS  1 = digit i holds a committed legal glyph.
- update  output  1  one-cycle pulse on every legal commit.
- error  output  1  one-cycle pulse on a commit of an illegal pattern.
- error_digit  output  4  index of the digit that produced the last error; held until the next error.

Behaviour:
- Reset: value=0, valid_mask=0, update=0, error=0, error_digit=0, FSM=WAIT, stability counter=0.
- Glyph table (segment hex -> nibble):
  - 3F->0, 06->1, 5B->2, 4F->3, 66->4, 6D->5, 7D->6, 07->7
  - 7F->8, 6F->9, 77->A, 7C->B, 39->C, 5E->D, 79->E, 71->F
- 00 = blank. Any other pattern is illegal.
- Input stage: {digit_sel, segment} is registered every cycle into a sample register. The counter increments while the new sample equals the previous sample, saturates, and resets to 0 on any change.
- FSM states:
  - WAIT: digit_sel sample is not one-hot (zero or multiple bits set). No commit. Go to TRACK when a one-hot sample is seen.
  - TRACK: counting. When the sample has been identical for STABLE_CYCLES consecutive edges, commit and go to DONE. Any sample change restarts the count. A non-one-hot sample returns to WAIT.
  - DONE: committed. Stays until the sample changes, then goes to TRACK (one-hot) or WAIT (not one-hot). The same pattern never commits twice.
- Commit timing: a pair first present before edge t0 and held is committed, and outputs are visible, after edge t0+STABLE_CYCLES.
- Commit action:
  - Legal glyph: value[i] := nibble, valid_mask[i] := 1, update=1 for 1 cycle.
  - Blank: valid_mask[i] := 0, value[i] unchanged, no pulse.
  - Illegal pattern: value and valid_mask unchanged, error=1 for 1 cycle, error_digit := i.
- clear:
  - Sets value=0 and valid_mask=0, and the FSM to WAIT with counter=0.
  - Wins over a commit in the same cycle; no update or error pulse that cycle.
  - error_digit is kept.
- Reset mid-scan aborts any partial count; no pulse is emitted.
- Only one digit can commit per cycle. update and error are never high together.

Optional Feature:
- SEG_ACTIVE_LOW_EN defined: segment and digit_sel are inverted at the input stage for common-anode displays (0 = lit / selected). All tables and outputs are unchanged.
- Undefined: active-high inputs as above.

Decomposition:
- Shared header include: the 16 glyph pattern constants, the blank constant, and FSM state encodings (WAIT=0, TRACK=1, DONE=2).
- Sub-module seg7_to_hex: combinational, segment[6:0] -> {legal, blank, nibble[3:0]}. It is instantiated once, after the sample register.
- One-hot check and index encode stay inline.

Test Plan:
- Reset, then digit_sel=01, segment=5B held 6 cycles -> after edge t0+4, value[3:0]=2, valid_mask=01, update high exactly 1 cycle, no further pulses.
- Scan digits 0..3 with 06,4F,6D,7F, each held 5 cycles -> value[15:0]=16'h8531, valid_mask=0F, 4 update pulses.
- Hold digit_sel=04 and segment=7F for 3 cycles, then change to 06 -> no commit of 8. After 4 more stable cycles, digit 2 = 1.
- digit_sel=02, segment=49 held 4 cycles -> error pulse, error_digit=1, value and valid_mask unchanged.
- digit_sel=03 (two bits set) with segment=3F held 10 cycles -> no update, no error. Then segment=00 on a valid digit -> that valid bit clears.
- Assert clear on the exact commit cycle -> value=0, valid_mask=0, no update. With SEG_ACTIVE_LOW_EN defined, repeat scenario 1 with inverted inputs -> identical outputs.

Source files
------------

// File: rtl/seg7_scan_reader_pkg.sv
// Shared constants for the seven-segment scan reader: glyph patterns,
// the blank pattern and the scan FSM state encoding.
package seg7_scan_reader_pkg;

  // Index n holds the segment pattern (bit0=a .. bit6=g) that displays hex digit n.
  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_TRACK = 2'd1,
    ST_DONE  = 2'd2
  } scan_state_t;

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational inverse of the hex-to-seven-segment decoder: classifies a
// pattern as a legal glyph (with its nibble), blank, or neither.
module seg7_to_hex
  import seg7_scan_reader_pkg::*;
(
  input  logic [6:0] segment,
  output logic       legal,
  output logic       blank,
  output logic [3:0] nibble
);

  always_comb begin
    legal  = 1'b0;
    nibble = 4'd0;
    for (int n = 0; n < 16; n++) begin
      if (segment == GLYPH[n]) begin
        legal  = 1'b1;
        nibble = 4'(n);
      end
    end
  end

  assign blank = (segment == SEG_BLANK);

endmodule

// File: rtl/seg7_scan_reader.sv
// Recovers hex digits from a scanned seven-segment bus. Each {digit_sel, segment}
// pair must stay stable for STABLE_CYCLES edges before it is committed once.
// Define SEG_ACTIVE_LOW_EN for common-anode (active-low) segment and select inputs.
module seg7_scan_reader
  import seg7_scan_reader_pkg::*;
#(
  parameter int DIGITS        = 8,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [6:0]          segment,
  input  logic [DIGITS-1:0]   digit_sel,
  input  logic                clear,
  output logic [4*DIGITS-1:0] value,
  output logic [DIGITS-1:0]   valid_mask,
  output logic                update,
  output logic                error,
  output logic [3:0]          error_digit
);

  localparam int SW = DIGITS + 7;
  localparam int CW = $clog2(STABLE_CYCLES + 1);

  logic [SW-1:0]     raw_in;
  logic [SW-1:0]     sample_reg;
  logic [CW-1:0]     count_reg, count_next;
  scan_state_t       state_reg, state_next;
  logic              update_reg, error_reg;
  logic [3:0]        error_digit_reg;
  logic              same, onehot_new, commit;
  logic [DIGITS-1:0] sel_new, sel_reg;
  logic [3:0]        sel_index;
  logic              glyph_legal, glyph_blank;
  logic [3:0]        glyph_nibble;

`ifdef SEG_ACTIVE_LOW_EN
  assign raw_in = ~{digit_sel, segment};
`else
  assign raw_in = {digit_sel, segment};
`endif

  assign sel_new    = raw_in[SW-1:7];
  assign sel_reg    = sample_reg[SW-1:7];
  assign same       = (raw_in == sample_reg);
  assign onehot_new = (sel_new != '0) && ((sel_new & (sel_new - DIGITS'(1))) == '0);

  // The count reaches STABLE_CYCLES on the edge where the pair has been held that long.
  always_comb begin
    count_next = '0;
    if (same) begin
      count_next = (count_reg == CW'(STABLE_CYCLES)) ? count_reg : count_reg + CW'(1);
    end
  end

  always_comb begin
    sel_index = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (sel_reg[i]) sel_index = 4'(i);
    end
  end

  // Decoding the registered sample is safe: a commit requires the incoming pair to equal it.
  seg7_to_hex u_to_hex (
    .segment (sample_reg[6:0]),
    .legal   (glyph_legal),
    .blank   (glyph_blank),
    .nibble  (glyph_nibble)
  );

  always_comb begin
    state_next = state_reg;
    commit     = 1'b0;
    case (state_reg)
      ST_WAIT: begin
        if (onehot_new) state_next = ST_TRACK;
      end
      ST_TRACK: begin
        if (!same) begin
          state_next = onehot_new ? ST_TRACK : ST_WAIT;
        end else if (count_next == CW'(STABLE_CYCLES)) begin
          commit     = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!same) state_next = onehot_new ? ST_TRACK : ST_WAIT;
      end
      default: state_next = ST_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sample_reg      <= '0;
      count_reg       <= '0;
      state_reg       <= ST_WAIT;
      update_reg      <= 1'b0;
      error_reg       <= 1'b0;
      error_digit_reg <= 4'd0;
    end else begin
      sample_reg <= raw_in;
      update_reg <= 1'b0;
      error_reg  <= 1'b0;
      if (clear) begin
        count_reg <= '0;
        state_reg <= ST_WAIT;
      end else begin
        count_reg <= count_next;
        state_reg <= state_next;
        if (commit) begin
          if (glyph_legal) begin
            update_reg <= 1'b1;
          end else if (!glyph_blank) begin
            error_reg       <= 1'b1;
            error_digit_reg <= sel_index;
          end
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] nibble_reg;
      logic       valid_reg;
      logic       hit;

      assign hit = commit && !clear && sel_reg[gi];

      always_ff @(posedge clk) begin
        if (reset || clear) begin
          nibble_reg <= 4'd0;
          valid_reg  <= 1'b0;
        end else if (hit) begin
          if (glyph_legal) begin
            nibble_reg <= glyph_nibble;
            valid_reg  <= 1'b1;
          end else if (glyph_blank) begin
            valid_reg <= 1'b0;
          end
        end
      end

      assign value[4*gi +: 4] = nibble_reg;
      assign valid_mask[gi]   = valid_reg;
    end
  endgenerate

  assign update      = update_reg;
  assign error       = error_reg;
  assign error_digit = error_digit_reg;

endmodule
